// File: rtl/conv_sequencer_pkg.sv
// Shared types and widths for the sequential 1-D convolution controller.
// Optional feature macro: CONV_SEQ_SIGNED_EN (two's-complement operands).
package conv_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_N,
    LOAD_M,
    MAC,
    EMIT
  } conv_state_e;

endpackage

// File: rtl/conv_sequencer_if.sv
// Operand input stream and result output stream of the convolution controller.
interface conv_sequencer_if;
  import conv_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  out_valid;
  logic  out_ready;
  acc_t  out_data;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_sequencer_mac.sv
// Single shared 16x16 multiply-accumulate unit, 32-bit wrapping accumulator.
// CONV_SEQ_SIGNED_EN selects sign extension of both operands.
module conv_mac
  import conv_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  data_t a,
  input  data_t b,
  output acc_t  acc
);

  acc_t w_a_ext;
  acc_t w_b_ext;
  acc_t w_prod;
  acc_t r_acc;

`ifdef CONV_SEQ_SIGNED_EN
  assign w_a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
  assign w_b_ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
`else
  assign w_a_ext = {{(ACC_W-DATA_W){1'b0}}, a};
  assign w_b_ext = {{(ACC_W-DATA_W){1'b0}}, b};
`endif

  // Low 32 bits of the extended product equal the 16x16 product in either mode
  assign w_prod = w_a_ext * w_b_ext;

  // Accumulator: clear has priority over accumulate, wraps modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/conv_sequencer.sv
// Sequential 1-D convolution controller: loads N+M operands, then computes
// the N+M-1 outputs one MAC term per cycle on a shared conv_mac.
// Optional feature macro: CONV_SEQ_SIGNED_EN (handled inside conv_mac).
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  conv_sequencer_if.slave  bus,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW  = $clog2(N + M);
  localparam int unsigned NIW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MIW = (M > 1) ? $clog2(M) : 1;

  conv_state_e   r_state;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_done;
  data_t         r_buf_n [N];
  data_t         r_buf_m [M];

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_last_m_beat;
  logic          w_last_out;
  logic          w_mac_clr;
  logic          w_mac_en;
  data_t         w_a;
  data_t         w_b;
  acc_t          w_acc;

  // First j contributing to output i
  function automatic logic [CW-1:0] f_jmin(input logic [CW-1:0] i);
    return (i >= CW'(M - 1)) ? (i - CW'(M - 1)) : '0;
  endfunction

  // Last j contributing to output i
  function automatic logic [CW-1:0] f_jmax(input logic [CW-1:0] i);
    return (i < CW'(N - 1)) ? i : CW'(N - 1);
  endfunction

  assign w_in_fire     = r_in_ready & bus.in_valid;
  assign w_out_fire    = r_out_valid & bus.out_ready;
  assign w_last_m_beat = (r_state == LOAD_M) && w_in_fire && (r_k == CW'(M - 1));
  assign w_last_out    = (r_i == CW'(N + M - 2));
  assign w_mac_clr     = w_last_m_beat || ((r_state == EMIT) && w_out_fire);
  assign w_mac_en      = (r_state == MAC);
  assign w_a           = r_buf_n[NIW'(r_j)];
  assign w_b           = r_buf_m[MIW'(r_i - r_j)];

  // Controller FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD_N;
            r_k        <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        LOAD_N: begin
          if (w_in_fire) begin
            if (r_k == CW'(N - 1)) begin
              r_k     <= '0;
              r_state <= LOAD_M;
            end else begin
              r_k <= r_k + CW'(1);
            end
          end
        end
        LOAD_M: begin
          if (w_in_fire) begin
            if (w_last_m_beat) begin
              r_k        <= '0;
              r_i        <= '0;
              r_j        <= f_jmin('0);
              r_in_ready <= 1'b0;
              r_state    <= MAC;
            end else begin
              r_k <= r_k + CW'(1);
            end
          end
        end
        MAC: begin
          if (r_j == f_jmax(r_i)) begin
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        EMIT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (w_last_out) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_i     <= r_i + CW'(1);
              r_j     <= f_jmin(r_i + CW'(1));
              r_state <= MAC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand buffers: written only by accepted load beats, retained after done
  always_ff @(posedge clk) begin
    if ((r_state == LOAD_N) && w_in_fire) begin
      r_buf_n[NIW'(r_k)] <= bus.in_data;
    end
    if ((r_state == LOAD_M) && w_in_fire) begin
      r_buf_m[MIW'(r_k)] <= bus.in_data;
    end
  end

  conv_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_mac_clr),
    .en    (w_mac_en),
    .a     (w_a),
    .b     (w_b),
    .acc   (w_acc)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_acc;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: instance 0 is N=4,M=3, instance 1 is N=2,M=2.
// Honours CONV_SEQ_SIGNED_EN in its reference model and constant table.
module tb_conv_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;

  logic [1:0]       start;
  logic [1:0]       in_valid;
  logic [1:0][15:0] in_data;
  logic [1:0]       out_ready;
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [1:0][31:0] out_data;
  wire  [1:0]       busy;
  wire  [1:0]       done;

  int n_vec;
  int n_bad;

  conv_sequencer_if ifa ();
  conv_sequencer_if ifb ();

  assign ifa.in_valid  = in_valid[0];
  assign ifa.in_data   = in_data[0];
  assign ifa.out_ready = out_ready[0];
  assign in_ready[0]   = ifa.in_ready;
  assign out_valid[0]  = ifa.out_valid;
  assign out_data[0]   = ifa.out_data;

  assign ifb.in_valid  = in_valid[1];
  assign ifb.in_data   = in_data[1];
  assign ifb.out_ready = out_ready[1];
  assign in_ready[1]   = ifb.in_ready;
  assign out_valid[1]  = ifb.out_valid;
  assign out_data[1]   = ifb.out_data;

  conv_sequencer #(.N(4), .M(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start[0]),
    .bus   (ifa.slave),
    .busy  (busy[0]),
    .done  (done[0])
  );

  conv_sequencer #(.N(2), .M(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start[1]),
    .bus   (ifb.slave),
    .busy  (busy[1]),
    .done  (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    int              d;
    int              nn;
    int              mm;
    logic [7:0][15:0] v;
    logic [7:0][31:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic longint ext(input logic [15:0] x);
`ifdef CONV_SEQ_SIGNED_EN
    return {{48{x[15]}}, x};
`else
    return {48'd0, x};
`endif
  endfunction

  // Reference: y[i] = sum over all valid (j, i-j) of a[j]*b[i-j], mod 2^32
  function automatic void model(input int nn, input int mm, input logic [15:0] v[$],
                                output logic [31:0] y[$]);
    logic [31:0] acc;
    y = {};
    for (int i = 0; i < nn + mm - 1; i++) begin
      acc = '0;
      for (int j = 0; j < nn; j++) begin
        if ((i - j) >= 0 && (i - j) < mm)
          acc = acc + 32'(ext(v[j]) * ext(v[nn + i - j]));
      end
      y.push_back(acc);
    end
  endfunction

  task automatic add_vec(input int d, input int nn, input int mm,
                         input logic [15:0] v[$], input logic [31:0] e[$]);
    vec_t t;
    t = '0;
    t.d  = d;
    t.nn = nn;
    t.mm = mm;
    foreach (v[k]) t.v[k] = v[k];
    foreach (e[k]) t.ex[k] = e[k];
    tbl.push_back(t);
  endtask

  task automatic chk_reset_vals(input int d);
    chk($sformatf("rst in_ready[%0d]", d), 32'(in_ready[d]), 32'd0);
    chk($sformatf("rst out_valid[%0d]", d), 32'(out_valid[d]), 32'd0);
    chk($sformatf("rst out_data[%0d]", d), out_data[d], 32'd0);
    chk($sformatf("rst busy[%0d]", d), 32'(busy[d]), 32'd0);
    chk($sformatf("rst done[%0d]", d), 32'(done[d]), 32'd0);
  endtask

  // One full job; abort_at>0 resets the design during MAC of output abort_at
  task automatic run_job(input int d, input int nn, input int mm,
                         input logic [15:0] vals[$], input logic [31:0] ex[$],
                         input int stall, input bit gaps, input bit disturb,
                         input int abort_at);
    int tmo;
    int c0;
    logic [31:0] got;
    bit unstable;

    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("busy after start", 32'(busy[d]), 32'd1);
    chk("in_ready after start", 32'(in_ready[d]), 32'd1);

    foreach (vals[b]) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid[d] = 1'b0;
        @(negedge clk);
      end
      in_valid[d] = 1'b1;
      in_data[d]  = vals[b];
      tmo = 0;
      while (!in_ready[d] && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 50) begin
        chk("load timeout", 32'd1, 32'd0);
        in_valid[d] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    c0 = cyc;
    chk("in_ready after load", 32'(in_ready[d]), 32'd0);
    start[d] = disturb;

    for (int k = 0; k < nn + mm - 1; k++) begin
      tmo = 0;
      while (!out_valid[d] && tmo < 200) begin
        @(negedge clk);
        start[d] = 1'b0;
        tmo++;
      end
      start[d] = 1'b0;
      if (tmo >= 200) begin
        chk("out_valid timeout", 32'd1, 32'd0);
        return;
      end
      got = out_data[d];
      if (disturb) begin
        in_valid[d] = 1'b1;
        in_data[d]  = 16'($urandom);
      end
      unstable = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        in_valid[d] = 1'b0;
        if (out_valid[d] !== 1'b1 || out_data[d] !== got) unstable = 1'b1;
      end
      if (stall > 0) chk($sformatf("hold y[%0d]", k), 32'(unstable), 32'd0);
      chk($sformatf("dut%0d y[%0d]", d, k), got, ex[k]);
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      in_valid[d]  = 1'b0;
      if (abort_at == k + 1) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(d);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    chk("done pulse", 32'(done[d]), 32'd1);
    chk("busy at done", 32'(busy[d]), 32'd0);
    chk("mac-to-done cycles", 32'(cyc - c0), 32'(nn * mm + (nn + mm - 1) * (1 + stall)));
    @(negedge clk);
    chk("done single", 32'(done[d]), 32'd0);
  endtask

  initial begin
    logic [15:0] qv[$];
    logic [31:0] qe[$];
    int d, nn, mm;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant vectors
    qv = '{16'd1, 16'd2, 16'd3, 16'd4};
    qe = '{32'd3, 32'd10, 32'd8};
    add_vec(1, 2, 2, qv, qe);
    qv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1};
    qe = '{32'd1, 32'd3, 32'd6, 32'd9, 32'd7, 32'd4};
    add_vec(0, 4, 3, qv, qe);
    qv = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`ifdef CONV_SEQ_SIGNED_EN
    qe = '{32'd1, 32'd2, 32'd1};
`else
    qe = '{32'hFFFE0001, 32'hFFFC0002, 32'hFFFE0001};
`endif
    add_vec(1, 2, 2, qv, qe);

    foreach (tbl[t]) begin
      qv = {};
      qe = {};
      for (int k = 0; k < tbl[t].nn + tbl[t].mm; k++) qv.push_back(tbl[t].v[k]);
      for (int k = 0; k < tbl[t].nn + tbl[t].mm - 1; k++) qe.push_back(tbl[t].ex[k]);
      run_job(tbl[t].d, tbl[t].nn, tbl[t].mm, qv, qe, 0, 1'b0, 1'b0, 0);
    end

    // Backpressure: 5 stall cycles in every EMIT
    qv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1};
    qe = '{32'd1, 32'd3, 32'd6, 32'd9, 32'd7, 32'd4};
    run_job(0, 4, 3, qv, qe, 5, 1'b0, 1'b0, 0);

    // start during MAC and in_valid during EMIT are ignored
    run_job(0, 4, 3, qv, qe, 1, 1'b0, 1'b1, 0);

    // Reset while computing output 2, then a fresh job
    run_job(0, 4, 3, qv, qe, 0, 1'b0, 1'b0, 2);
    qv = '{16'd5, 16'd0, 16'd7, 16'd2, 16'd3, 16'd9, 16'd4};
    model(4, 3, qv, qe);
    run_job(0, 4, 3, qv, qe, 0, 1'b1, 1'b0, 0);

    // Randomized jobs against the reference model
    for (int r = 0; r < 24; r++) begin
      d  = r % 2;
      nn = (d == 0) ? 4 : 2;
      mm = (d == 0) ? 3 : 2;
      qv = {};
      for (int k = 0; k < nn + mm; k++)
        qv.push_back(($urandom_range(1) == 0) ? 16'($urandom_range(15)) : 16'($urandom));
      model(nn, mm, qv, qe);
      run_job(d, nn, mm, qv, qe, $urandom_range(2), 1'b1, 1'($urandom_range(1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
